// File: rtl/bcd_score_encoder.sv
// Iterative double-dabble binary-to-BCD encoder feeding the seven-segment display driver.
// Latency BIN_WIDTH+1 cycles from start to done. Start is ignored while busy. bcd_out and overflow hold between completions.
module bcd_score_encoder #(
    parameter int BIN_WIDTH = 16,
    parameter int DIGITS    = 4
) (
    input  logic                   clock_100Mhz,
    input  logic                   reset,
    input  logic                   start,
    input  logic [BIN_WIDTH-1:0]   bin_in,
    output logic                   busy,
    output logic                   done,
    output logic [4*DIGITS-1:0]    bcd_out,
    output logic                   overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam logic [63:0]      MAX_DEC   = pow10(DIGITS) - 64'd1;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(BIN_WIDTH - 1);
    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [BIN_WIDTH-1:0] shift_reg;
    logic [BIN_WIDTH-1:0] shift_reg_nxt;
    logic [BCD_W-1:0]     scratch;
    logic [BCD_W-1:0]     scratch_nxt;
    logic [BCD_W-1:0]     scratch_adj;
    logic [BCD_W-1:0]     scratch_shl;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 ovf_pending;
    logic                 ovf_pending_nxt;
    logic                 done_nxt;
    logic [BCD_W-1:0]     bcd_nxt;
    logic                 overflow_nxt;
    logic                 bin_ovf;

    assign bin_ovf = (64'(bin_in) > MAX_DEC);
    assign busy    = (state == SHIFT);

    // Add-3 correction works on the pre-shift scratch; the shift follows in the same cycle.
    always_comb begin
        scratch_adj = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) begin
                scratch_adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
            end
        end
        scratch_shl = {scratch_adj[BCD_W-2:0], shift_reg[BIN_WIDTH-1]};
    end

    always_comb begin
        state_nxt       = state;
        shift_reg_nxt   = shift_reg;
        scratch_nxt     = scratch;
        cnt_nxt         = cnt;
        ovf_pending_nxt = ovf_pending;
        done_nxt        = 1'b0;
        bcd_nxt         = bcd_out;
        overflow_nxt    = overflow;

        case (state)
            IDLE: begin
                if (start) begin
                    shift_reg_nxt   = bin_in;
                    scratch_nxt     = '0;
                    cnt_nxt         = CNT_LOAD;
                    ovf_pending_nxt = bin_ovf;
                    state_nxt       = SHIFT;
                end
            end
            SHIFT: begin
                shift_reg_nxt = {shift_reg[BIN_WIDTH-2:0], 1'b0};
                scratch_nxt   = scratch_shl;
                if (cnt == '0) begin
                    // Top-digit carries are lost on overflow, so the saturated value replaces the result.
                    bcd_nxt      = ovf_pending ? ALL_NINES : scratch_shl;
                    overflow_nxt = ovf_pending;
                    done_nxt     = 1'b1;
                    state_nxt    = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            state       <= IDLE;
            shift_reg   <= '0;
            scratch     <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
            done        <= 1'b0;
            bcd_out     <= '0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_nxt;
            shift_reg   <= shift_reg_nxt;
            scratch     <= scratch_nxt;
            cnt         <= cnt_nxt;
            ovf_pending <= ovf_pending_nxt;
            done        <= done_nxt;
            bcd_out     <= bcd_nxt;
            overflow    <= overflow_nxt;
        end
    end

endmodule

// File: doc/bcd_score_encoder.md
Name: bcd_score_encoder

Overview:
Sequential binary-to-BCD encoder that produces the packed decimal digits consumed by the 4-digit seven-segment display driver. It replaces per-digit combinational divide/modulo. It uses an iterative shift-and-add-3 (double-dabble) engine with a start/busy/done handshake. Game logic drives a binary score or timer value in, and the display side reads a stable, held bcd_out.

Parameters:
BIN_WIDTH, 16, width of the binary input; also the number of shift cycles per conversion.
DIGITS, 4, number of BCD digits produced; bcd_out width is 4*DIGITS; saturation value is 10^DIGITS-1.

Ports:
clock_100Mhz  input  1  system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  conversion request; sampled only in IDLE.
bin_in  input  BIN_WIDTH  unsigned binary value; captured on the edge that accepts start.
busy  output  1  high while a conversion is in progress (SHIFT state).
done  output  1  single-cycle pulse when bcd_out has been updated.
bcd_out  output  4*DIGITS  packed BCD; most significant digit in the top nibble; held between conversions.
overflow  output  1  set when the last converted value exceeded 10^DIGITS-1; held with bcd_out.

Behaviour:
- Reset (synchronous, active-high; takes priority over everything):
  - State goes to IDLE.
  - busy=0, done=0, overflow=0, bcd_out=0.
  - The scratch register and shift counter are cleared.
  - Reset asserted mid-conversion aborts it; bcd_out reads 0 afterwards, not the old value.
- States: IDLE, SHIFT.
- IDLE:
  - done is driven 0 unless this is the first cycle after completion (see below).
  - On an edge with start=1:
    - Capture bin_in into the shift register.
    - Clear the DIGITS*4-bit BCD scratch.
    - Load counter = BIN_WIDTH-1.
    - Register ovf_pending = (bin_in > 10^DIGITS-1).
    - Go to SHIFT; busy=1.
- SHIFT, on each edge:
  - Every scratch nibble ≥5 gets +3.
  - Then {scratch, shiftreg} shifts left by 1, with the shiftreg MSB entering the scratch LSB.
  - The add-3 correction uses the pre-shift value within the same cycle.
  - Scratch bits shifted out of the top are discarded; lower digits remain correct and the result is overridden on overflow.
  - Counter decrements.
  - On the edge where counter==0 (the BIN_WIDTH-th shift):
    - bcd_out <= ovf_pending ? all-nines (16'h9999 for DIGITS=4) : shifted scratch.
    - overflow <= ovf_pending.
    - done <= 1; busy <= 0; state goes to IDLE.
- Latency:
  - start is accepted at edge 0.
  - bcd_out is valid and done=1 in the cycle after edge BIN_WIDTH (edge 16 for the default).
- done:
  - Exactly one cycle wide.
  - It clears on the next edge even if start is asserted then.
- start while busy is ignored: no restart, no queuing, bin_in is not re-sampled.
- start held high continuously gives back-to-back conversions.
  - The new conversion is accepted on the edge where done is high (the first IDLE cycle).
  - Throughput is one result per BIN_WIDTH+1 cycles.
- bcd_out and overflow change only on a completion edge or on reset.
  - There are no intermediate values, so the display never shows partial digits.
- bin_in is free to change after acceptance without affecting the conversion in progress.
- Boundaries:
  - bin_in=0 gives 0000.
  - bin_in=10^DIGITS-1 gives all nines with overflow=0.
  - bin_in=10^DIGITS gives all nines with overflow=1.
  - Max input (2^BIN_WIDTH-1) saturates.
- The counter is $clog2(BIN_WIDTH) bits and wraps only via reload; it must not underflow in IDLE.

Test Plan:
- Reset, then start with bin_in=0 → busy=1 for 16 cycles; done=1 for exactly 1 cycle at cycle 16 after acceptance; bcd_out=16'h0000, overflow=0.
- bin_in=1234, one-cycle start → bcd_out=16'h1234 at the done cycle; busy falls the same edge done rises; outputs held 50 cycles later with start=0.
- Boundaries:
  - bin_in=9999 → 16'h9999, overflow=0.
  - bin_in=10000 → 16'h9999, overflow=1.
  - bin_in=65535 → 16'h9999, overflow=1.
  - Then bin_in=30 → 16'h0030, overflow cleared.
- Start 30, then pulse start with bin_in=7 at cycle 5 and change bin_in mid-conversion → result 16'h0030 only; single done pulse; no second conversion.
- Assert reset at cycle 8 of a conversion of 4321 → next cycle busy=0, done=0, bcd_out=0, overflow=0; no done pulse follows; a new start with 42 yields 16'h0042 after 16 cycles.
- start held high, bin_in stepping 0,2,4,…,30 → results 0000,0002,…,0030 at a done pulse every 17 cycles, each done exactly one cycle.
